// File: rtl/uart_pkg.sv
// Shared types and character constants for the UART echo buffer.
// The CR->CRLF expansion is enabled by defining UART_ECHO_CRLF_EN.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_LF = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/echo_fifo.sv
// Small synchronous byte FIFO for the echo path: combinational head, pop strobe.
// A push into a full FIFO is accepted only when a pop happens at the same edge.
module echo_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buf.sv
// Echo-path byte buffer: FIFO plus a valid/ready output stage with sticky overflow.
// Define UART_ECHO_CRLF_EN to follow every transmitted CR with an inserted LF.
module uart_echo_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr
);

  state_t      state;
  state_t      next_state;
  logic [7:0]  data_reg;
  logic [7:0]  head;
  logic        pop;
  logic        full;
  logic        empty;
  logic        xfer;
  logic        drop;

  echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (rx_valid),
    .wdata (rx_data),
    .pop   (pop),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign xfer = tx_valid && tx_ready;
  assign drop = rx_valid && full && !pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      data_reg <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) data_reg <= head;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Popping on the transfer edge keeps the output register full for back-to-back bytes.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef UART_ECHO_CRLF_EN
          if (data_reg == CHAR_CR) next_state = SEND_LF;
          else if (!empty)         pop = 1'b1;
          else                     next_state = IDLE;
`else
          if (!empty) pop = 1'b1;
          else        next_state = IDLE;
`endif
        end
      end
`ifdef UART_ECHO_CRLF_EN
      SEND_LF: begin
        if (xfer) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = SEND;
          end else begin
            next_state = IDLE;
          end
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = data_reg;
    case (state)
      SEND: tx_valid = 1'b1;
`ifdef UART_ECHO_CRLF_EN
      SEND_LF: begin
        tx_valid = 1'b1;
        tx_data  = CHAR_LF;
      end
`endif
      default: tx_valid = 1'b0;
    endcase
  end

endmodule
